// File: rtl/dcc_pkg.sv
// Shared types, default timing and counter-width helpers for the DCC packet encoder.
package dcc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    START,
    DATA,
    CK_START,
    CK_DATA,
    END
  } dcc_state_e;

  // Default half-bit durations at 50 MHz: 58 us for '1', 100 us for '0'.
  localparam int DCC_ONE_HALF_CYC  = 2900;
  localparam int DCC_ZERO_HALF_CYC = 5000;
  localparam int DCC_PREAMBLE_BITS = 14;
  localparam int DCC_CHECKSUM_EN   = 1;

  // Half counter only ever counts 0 .. ZERO_HALF_CYC-1.
  function automatic int half_cnt_w(input int zero_half_cyc);
    return (zero_half_cyc < 2) ? 1 : $clog2(zero_half_cyc);
  endfunction

  // Bit counter must hold the preamble length or a full byte (8), whichever is larger.
  function automatic int bit_cnt_w(input int preamble_bits);
    int m;
    m = (preamble_bits > 8) ? preamble_bits : 8;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/dcc_bit_timer.sv
// Half-bit timer: shapes each bit as low half then high half, flags the bit boundary
// (last cycle of the high half) and strobes the first cycle of every bit.
module dcc_bit_timer
  import dcc_pkg::*;
#(
  parameter int ONE_HALF_CYC  = DCC_ONE_HALF_CYC,
  parameter int ZERO_HALF_CYC = DCC_ZERO_HALF_CYC
) (
  input  logic clk,
  input  logic reset,
  input  logic i_next_bit,   // value of the bit that starts after the current boundary
  output logic o_dcc,        // phase level: 0 in low half, 1 in high half
  output logic o_dcc_n,
  output logic o_strobe,
  output logic o_boundary
);

  localparam int CW = half_cnt_w(ZERO_HALF_CYC);
  localparam logic [CW-1:0] ONE_LAST  = CW'(ONE_HALF_CYC - 1);
  localparam logic [CW-1:0] ZERO_LAST = CW'(ZERO_HALF_CYC - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  logic [CW-1:0] r_cnt;
  logic          r_phase;
  logic          r_bit;
  logic          r_out;
  logic          r_out_n;
  logic          r_strobe;
  logic          r_first;

  logic w_half_last;
  logic w_boundary;

  // r_first makes the cycle straight after reset behave as a boundary, so the
  // first low half begins on the first rising edge after reset is released.
  always_comb begin
    w_half_last = (r_cnt == (r_bit ? ONE_LAST : ZERO_LAST));
    w_boundary  = r_first | (r_phase & w_half_last);
  end

  // Half counter, phase and registered complementary outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_phase  <= 1'b1;
      r_bit    <= 1'b1;
      r_out    <= 1'b1;
      r_out_n  <= 1'b0;
      r_strobe <= 1'b0;
      r_first  <= 1'b1;
    end else if (w_boundary) begin
      r_first  <= 1'b0;
      r_bit    <= i_next_bit;
      r_phase  <= 1'b0;
      r_cnt    <= '0;
      r_out    <= 1'b0;
      r_out_n  <= 1'b1;
      r_strobe <= 1'b1;
    end else if (w_half_last) begin
      r_phase  <= 1'b1;
      r_cnt    <= '0;
      r_out    <= 1'b1;
      r_out_n  <= 1'b0;
      r_strobe <= 1'b0;
    end else begin
      r_cnt    <= r_cnt + CNT_ONE;
      r_strobe <= 1'b0;
    end
  end

  assign o_dcc      = r_out;
  assign o_dcc_n    = r_out_n;
  assign o_strobe   = r_strobe;
  assign o_boundary = w_boundary;

endmodule

// File: rtl/dcc_packet_encoder.sv
// DCC packet encoder: one-deep byte holding register, packet sequencing FSM
// (preamble, start bits, data MSB first, optional XOR checksum, end bit) and bit timer.
module dcc_packet_encoder
  import dcc_pkg::*;
#(
  parameter int ONE_HALF_CYC  = DCC_ONE_HALF_CYC,
  parameter int ZERO_HALF_CYC = DCC_ZERO_HALF_CYC,
  parameter int PREAMBLE_BITS = DCC_PREAMBLE_BITS,
  parameter int CHECKSUM_EN   = DCC_CHECKSUM_EN
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] byte_data,
  input  logic       byte_last,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       dcc_out,
  output logic       dcc_out_n,
  output logic       bit_strobe,
  output logic       busy,
  output logic       underrun
);

  localparam int BW = bit_cnt_w(PREAMBLE_BITS);
  localparam logic [BW-1:0] PRE_LOAD  = BW'(PREAMBLE_BITS);
  localparam logic [BW-1:0] BYTE_LOAD = BW'(8);
  localparam logic [BW-1:0] CNT_ONE   = BW'(1);

  dcc_state_e  r_state;
  logic [BW-1:0] r_bitcnt;
  logic [7:0]  r_shift;
  logic [7:0]  r_cksum;
  logic        r_last;
  logic        r_busy;
  logic [7:0]  r_hold_data;
  logic        r_hold_last;
  logic        r_hold_full;

  dcc_state_e  w_state_nxt;
  logic [BW-1:0] w_bitcnt_nxt;
  logic [7:0]  w_shift_nxt;
  logic [7:0]  w_cksum_nxt;
  logic        w_last_nxt;
  logic        w_busy_nxt;
  logic        w_consume;
  logic        w_underrun;
  logic        w_next_bit;
  logic        w_boundary;
  logic        w_accept;

  dcc_bit_timer #(
    .ONE_HALF_CYC (ONE_HALF_CYC),
    .ZERO_HALF_CYC(ZERO_HALF_CYC)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .i_next_bit(w_next_bit),
    .o_dcc     (dcc_out),
    .o_dcc_n   (dcc_out_n),
    .o_strobe  (bit_strobe),
    .o_boundary(w_boundary)
  );

  // Accept only into an empty holding register; consume only from a full one.
  assign w_accept = byte_valid & ~r_hold_full;

  // Next-state and next-bit decisions, all taken at the bit boundary.
  always_comb begin
    w_state_nxt  = r_state;
    w_bitcnt_nxt = r_bitcnt;
    w_shift_nxt  = r_shift;
    w_cksum_nxt  = r_cksum;
    w_last_nxt   = r_last;
    w_busy_nxt   = r_busy;
    w_consume    = 1'b0;
    w_underrun   = 1'b0;
    if (w_boundary) begin
      case (r_state)
        IDLE: begin
          if (r_hold_full) begin
            w_cksum_nxt  = '0;
            w_busy_nxt   = 1'b1;
            w_state_nxt  = PREAMBLE;
            w_bitcnt_nxt = PRE_LOAD;
          end
        end
        PREAMBLE: begin
          if (r_bitcnt == CNT_ONE) begin
            w_state_nxt = START;
            w_consume   = 1'b1;
          end else begin
            w_bitcnt_nxt = r_bitcnt - CNT_ONE;
          end
        end
        START: begin
          w_state_nxt  = DATA;
          w_bitcnt_nxt = BYTE_LOAD;
        end
        DATA: begin
          if (r_bitcnt == CNT_ONE) begin
            if (r_last) begin
              w_state_nxt = (CHECKSUM_EN != 0) ? CK_START : END;
            end else if (r_hold_full) begin
              w_state_nxt = START;
              w_consume   = 1'b1;
            end else begin
              w_underrun  = 1'b1;
              w_state_nxt = END;
            end
          end else begin
            w_shift_nxt  = {r_shift[6:0], 1'b0};
            w_bitcnt_nxt = r_bitcnt - CNT_ONE;
          end
        end
        CK_START: begin
          w_state_nxt  = CK_DATA;
          w_shift_nxt  = r_cksum;
          w_bitcnt_nxt = BYTE_LOAD;
        end
        CK_DATA: begin
          if (r_bitcnt == CNT_ONE) begin
            w_state_nxt = END;
          end else begin
            w_shift_nxt  = {r_shift[6:0], 1'b0};
            w_bitcnt_nxt = r_bitcnt - CNT_ONE;
          end
        end
        END: begin
          w_busy_nxt  = 1'b0;
          w_state_nxt = IDLE;
          if (r_hold_full) begin
            w_busy_nxt   = 1'b1;
            w_cksum_nxt  = '0;
            w_state_nxt  = PREAMBLE;
            w_bitcnt_nxt = PRE_LOAD;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
    // The checksum is folded in as each byte is loaded rather than bit by bit;
    // the XOR over the packet's bytes comes out the same.
    if (w_consume) begin
      w_shift_nxt = r_hold_data;
      w_last_nxt  = r_hold_last;
      w_cksum_nxt = r_cksum ^ r_hold_data;
    end
    case (w_state_nxt)
      START, CK_START: w_next_bit = 1'b0;
      DATA, CK_DATA:   w_next_bit = w_shift_nxt[7];
      default:         w_next_bit = 1'b1;
    endcase
  end

  // Packet sequencing state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_cksum  <= '0;
      r_last   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_shift  <= w_shift_nxt;
      r_cksum  <= w_cksum_nxt;
      r_last   <= w_last_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

  // One-deep holding register between the byte interface and the encoder.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hold_full <= 1'b0;
      r_hold_data <= '0;
      r_hold_last <= 1'b0;
    end else if (w_consume) begin
      r_hold_full <= 1'b0;
    end else if (w_accept) begin
      r_hold_full <= 1'b1;
      r_hold_data <= byte_data;
      r_hold_last <= byte_last;
    end
  end

  assign byte_ready = ~r_hold_full;
  assign busy       = r_busy;
  assign underrun   = w_underrun;

endmodule
